ghost_move_controller: RTL and testbench
========================================

Name: ghost_move_controller

Overview:
- Upstream stage of the Ghost2 position register: decides each ghost step and writes the new (x, y) through the register's en/readwrite write port.
- Every MOVE_PERIOD cycles it latches the ghost and Pac-Man coordinates and ranks the four directions toward the target.
- Probes the maze map for each candidate in rank order; the first open tile is written back as the ghost's new position.

Parameters:
- MOVE_PERIOD, 2_500_000, clock_50 cycles between move attempts (20 Hz at 50 MHz).
- GRID_W, 21, number of valid x columns (0..GRID_W-1).
- GRID_H, 21, number of valid y rows (0..GRID_H-1).
- SCATTER_X, 1, scatter-mode target x (optional feature only).
- SCATTER_Y, 1, scatter-mode target y (optional feature only).

Ports:
- clock_50  in  1  system clock, 50 MHz.
- reset_n  in  1  synchronous, active-low reset; clock clock_50.
- enable  in  1  game running; move timer advances only while high.
- pacman_x  in  5  current Pac-Man x.
- pacman_y  in  5  current Pac-Man y.
- ghost_x_in  in  5  current ghost x, from the position register x_out.
- ghost_y_in  in  5  current ghost y, from the position register y_out.
- map_x  out  5  map query x.
- map_y  out  5  map query y.
- map_tile  in  3  tile code at the queried (map_x, map_y), valid exactly 1 cycle after the address is driven.
- reg_x_out  out  5  new ghost x, to the register x_in.
- reg_y_out  out  5  new ghost y, to the register y_in.
- reg_en  out  1  register enable.
- reg_readwrite  out  1  0 = write, 1 = read/hold.
- busy  out  1  high in every state except IDLE.
- move_done  out  1  1-cycle pulse coincident with the write cycle.

Behaviour:
Reset state:
- State IDLE, timer 0.
- reg_en=0, reg_readwrite=1, busy=0, move_done=0.
- map_x, map_y, reg_x_out, reg_y_out = 0.
- A reset asserted mid-move aborts the move; no write is issued.

Timer:
- Counts 0..MOVE_PERIOD-1 while enable=1 and state=IDLE; holds its value while enable=0.
- At MOVE_PERIOD-1 it wraps to 0 and the FSM enters LATCH on the next cycle.

FSM: IDLE -> LATCH -> QUERY -> CHECK -> (QUERY | WRITE) -> IDLE.
- LATCH:
  - Capture ghost (gx, gy) and target (tx, ty).
  - dx = tx-gx, dy = ty-gy, computed as signed 6-bit values.
  - H = RIGHT if tx>gx, else LEFT. V = DOWN if ty>gy, else UP (y increases downward).
  - If |dx|>=|dy|, order = H, V, !V, !H; otherwise order = V, H, !H, !V.
  - Candidate index = 0.
  - If gx==tx and gy==ty, go directly to WRITE with new position = (gx, gy).
- QUERY:
  - Compute the candidate tile.
  - If the candidate is outside 0..GRID_W-1 / 0..GRID_H-1, treat it as blocked without a map access and advance the index in the same cycle.
  - Otherwise drive map_x/map_y and go to CHECK.
- CHECK:
  - map_tile==TILE_WALL: blocked. Advance the index and return to QUERY.
  - Any other tile code: candidate accepted, go to WRITE.
- All four candidates blocked: WRITE with (gx, gy), i.e. the ghost stays put.
- WRITE (exactly 1 cycle):
  - reg_en=1, reg_readwrite=0, reg_x_out/reg_y_out = new position, move_done=1.
  - Next state IDLE, where reg_en=0 and reg_readwrite=1 again.

Latency and ordering:
- Best case: 4 cycles from LATCH to WRITE inclusive.
- Worst case: LATCH + 4 x (QUERY+CHECK) + WRITE = 10 cycles.
- enable is sampled only in IDLE; a move already in progress completes even if enable drops.
- No write occurs outside WRITE.

Optional Feature:
- Macro: GHOST_SCATTER_EN.
- Defined:
  - A 7-bit move counter increments on every move_done and wraps at 80.
  - For counts 64..79 (16 moves), LATCH uses (SCATTER_X, SCATTER_Y) as the target instead of Pac-Man.
  - The move counter resets to 0.
- Undefined: the target is always (pacman_x, pacman_y) and the move counter logic is absent.

Decomposition:
- Shared package pacman_pkg:
  - COORD_W=5.
  - Tile codes TILE_EMPTY=3'd0, TILE_WALL=3'd1, TILE_DOT=3'd2.
  - Direction type {UP, DOWN, LEFT, RIGHT}.
  - State encoding for this FSM.
- One sub-module, ghost_dir_rank: purely combinational. Takes gx, gy, tx, ty and returns the 4-entry ordered direction list; it is registered in LATCH.

Test Plan:
- Ghost (2,2), Pac-Man (10,2), open map, MOVE_PERIOD=8 -> 8 cycles after reset release, one write of (3,2) with reg_en=1, reg_readwrite=0 and move_done for 1 cycle; 4 cycles from LATCH to WRITE.
- Ghost (2,2), Pac-Man (10,5), wall at (3,2) -> first CHECK blocked, second succeeds, write (2,3).
- Ghost (0,0), Pac-Man (0,0) -> direct WRITE of (0,0) with no map query; map_x/map_y are never driven.
- Ghost (0,5), all neighbours walls or out of bounds, Pac-Man (0,10) -> out-of-bounds LEFT is skipped without a map access; write (0,5).
- reset_n=0 during CHECK -> reg_en stays 0, state IDLE, timer 0; enable=0 for 20 cycles -> timer frozen and no writes.
- GHOST_SCATTER_EN defined, 64 moves done -> the 65th move heads toward (1,1); after 80 moves the target reverts to Pac-Man.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared Pac-Man definitions: coordinate width, maze tile codes, directions and
// the ghost move FSM states.
package pacman_pkg;
  localparam int COORD_W = 5;

  localparam logic [2:0] TILE_EMPTY = 3'd0;
  localparam logic [2:0] TILE_WALL  = 3'd1;
  localparam logic [2:0] TILE_DOT   = 3'd2;

  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

  typedef enum logic [2:0] {IDLE, LATCH, QUERY, CHECK, WRITE} ghost_state_t;

  // A neighbouring tile; ok=0 means it falls off the grid.
  typedef struct packed {
    logic               ok;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } cand_t;

  function automatic dir_t opposite(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction
endpackage

// File: rtl/ghost_dir_rank.sv
// Ranks the four step directions from the ghost toward its target: dominant axis
// first, then the minor axis, its reverse, and finally the dominant reverse.
module ghost_dir_rank
  import pacman_pkg::*;
(
  input  logic [COORD_W-1:0] gx,
  input  logic [COORD_W-1:0] gy,
  input  logic [COORD_W-1:0] tx,
  input  logic [COORD_W-1:0] ty,
  output dir_t               order [4]
);
  logic signed [COORD_W:0] dx, dy;
  logic [COORD_W:0] adx, ady;
  dir_t h, v;

  always_comb begin
    dx  = $signed({1'b0, tx}) - $signed({1'b0, gx});
    dy  = $signed({1'b0, ty}) - $signed({1'b0, gy});
    adx = dx[COORD_W] ? -dx : dx;
    ady = dy[COORD_W] ? -dy : dy;
    h   = (tx > gx) ? RIGHT : LEFT;
    v   = (ty > gy) ? DOWN : UP;
    if (adx >= ady) order = '{h, v, opposite(v), opposite(h)};
    else            order = '{v, h, opposite(h), opposite(v)};
  end
endmodule

// File: rtl/ghost_move_controller.sv
// Ghost step controller: every MOVE_PERIOD cycles probes the maze for the best open
// neighbour toward the target and writes it to the position register.
// Optional GHOST_SCATTER_EN: moves 64..79 of every 80 chase (SCATTER_X, SCATTER_Y).
module ghost_move_controller
  import pacman_pkg::*;
#(
  parameter int MOVE_PERIOD = 2_500_000,
  parameter int GRID_W      = 21,
  parameter int GRID_H      = 21
`ifdef GHOST_SCATTER_EN
  ,
  parameter int SCATTER_X   = 1,
  parameter int SCATTER_Y   = 1
`endif
) (
  input  logic               clock_50,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [COORD_W-1:0] pacman_x,
  input  logic [COORD_W-1:0] pacman_y,
  input  logic [COORD_W-1:0] ghost_x_in,
  input  logic [COORD_W-1:0] ghost_y_in,
  output logic [COORD_W-1:0] map_x,
  output logic [COORD_W-1:0] map_y,
  input  logic [2:0]         map_tile,
  output logic [COORD_W-1:0] reg_x_out,
  output logic [COORD_W-1:0] reg_y_out,
  output logic               reg_en,
  output logic               reg_readwrite,
  output logic               busy,
  output logic               move_done
);
  localparam int TW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(MOVE_PERIOD - 1);
  localparam logic signed [COORD_W+1:0] GW = (COORD_W+2)'(GRID_W);
  localparam logic signed [COORD_W+1:0] GH = (COORD_W+2)'(GRID_H);

  ghost_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0] idx_q, idx_d;
  logic [COORD_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [COORD_W-1:0] map_x_q, map_x_d, map_y_q, map_y_d;
  logic [COORD_W-1:0] new_x_q, new_x_d, new_y_q, new_y_d;
  dir_t order_q [4];
  dir_t order_d [4];
  dir_t rank [4];
  cand_t cand_q, cand_d, cand_first, cand_next;
  logic reg_en_q, rw_q, busy_q, done_q;
  logic advance;
  logic [COORD_W-1:0] tx, ty;

  function automatic cand_t step(input logic [COORD_W-1:0] x, y, input dir_t d);
    logic signed [COORD_W+1:0] nx, ny;
    cand_t c;
    nx = $signed({2'b00, x});
    ny = $signed({2'b00, y});
    case (d)
      UP:    ny = ny - 7'sd1;
      DOWN:  ny = ny + 7'sd1;
      LEFT:  nx = nx - 7'sd1;
      RIGHT: nx = nx + 7'sd1;
    endcase
    c.ok = !nx[COORD_W+1] && (nx < GW) && !ny[COORD_W+1] && (ny < GH);
    c.x  = nx[COORD_W-1:0];
    c.y  = ny[COORD_W-1:0];
    return c;
  endfunction

`ifdef GHOST_SCATTER_EN
  logic [6:0] moves_q, moves_d;
  always_comb begin
    moves_d = moves_q;
    if (state_q == WRITE) moves_d = (moves_q == 7'd79) ? 7'd0 : moves_q + 7'd1;
  end
  assign tx = (moves_q >= 7'd64) ? COORD_W'(SCATTER_X) : pacman_x;
  assign ty = (moves_q >= 7'd64) ? COORD_W'(SCATTER_Y) : pacman_y;
  always_ff @(posedge clock_50) begin
    if (!reset_n) moves_q <= '0;
    else          moves_q <= moves_d;
  end
`else
  assign tx = pacman_x;
  assign ty = pacman_y;
`endif

  ghost_dir_rank u_rank (
    .gx(ghost_x_in), .gy(ghost_y_in), .tx(tx), .ty(ty), .order(rank)
  );

  // The address for a candidate is registered on entry to QUERY so the tile
  // returns exactly while the FSM sits in CHECK.
  always_comb begin
    state_d = state_q;  timer_d = timer_q;  idx_d = idx_q;
    gx_d = gx_q;  gy_d = gy_q;  order_d = order_q;  cand_d = cand_q;
    map_x_d = map_x_q;  map_y_d = map_y_q;
    new_x_d = new_x_q;  new_y_d = new_y_q;
    advance = 1'b0;
    cand_first = step(ghost_x_in, ghost_y_in, rank[0]);
    cand_next  = step(gx_q, gy_q, order_q[idx_q + 2'd1]);
    unique case (state_q)
      IDLE: if (enable) begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          state_d = LATCH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      LATCH: begin
        gx_d = ghost_x_in;  gy_d = ghost_y_in;
        order_d = rank;  idx_d = '0;  cand_d = cand_first;
        if (ghost_x_in == tx && ghost_y_in == ty) begin
          state_d = WRITE;  new_x_d = ghost_x_in;  new_y_d = ghost_y_in;
        end else begin
          state_d = QUERY;
          if (cand_first.ok) begin map_x_d = cand_first.x;  map_y_d = cand_first.y; end
        end
      end
      QUERY: if (cand_q.ok) state_d = CHECK; else advance = 1'b1;
      CHECK: if (map_tile == TILE_WALL) advance = 1'b1;
             else begin state_d = WRITE;  new_x_d = cand_q.x;  new_y_d = cand_q.y; end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (advance) begin
      if (idx_q == 2'd3) begin
        state_d = WRITE;  new_x_d = gx_q;  new_y_d = gy_q;
      end else begin
        state_d = QUERY;  idx_d = idx_q + 2'd1;  cand_d = cand_next;
        if (cand_next.ok) begin map_x_d = cand_next.x;  map_y_d = cand_next.y; end
      end
    end
  end

  always_ff @(posedge clock_50) begin
    if (!reset_n) begin
      state_q <= IDLE;  timer_q <= '0;  idx_q <= '0;
      gx_q <= '0;  gy_q <= '0;  order_q <= '{default: UP};  cand_q <= '0;
      map_x_q <= '0;  map_y_q <= '0;  new_x_q <= '0;  new_y_q <= '0;
      reg_en_q <= 1'b0;  rw_q <= 1'b1;  busy_q <= 1'b0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d;  timer_q <= timer_d;  idx_q <= idx_d;
      gx_q <= gx_d;  gy_q <= gy_d;  order_q <= order_d;  cand_q <= cand_d;
      map_x_q <= map_x_d;  map_y_q <= map_y_d;  new_x_q <= new_x_d;  new_y_q <= new_y_d;
      reg_en_q <= (state_d == WRITE);
      rw_q     <= (state_d != WRITE);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == WRITE);
    end
  end

  assign map_x         = map_x_q;
  assign map_y         = map_y_q;
  assign reg_x_out     = new_x_q;
  assign reg_y_out     = new_y_q;
  assign reg_en        = reg_en_q;
  assign reg_readwrite = rw_q;
  assign busy          = busy_q;
  assign move_done     = done_q;
endmodule

// File: tb/tb_ghost_move_controller.sv
// Bench for ghost_move_controller: directed scenarios plus randomized mazes checked
// against a neighbour-ranking model of the ghost's chase rule.
module tb_ghost_move_controller;
  import pacman_pkg::*;
  localparam int MP = 8;
  localparam int N  = 21;

  logic clock_50 = 1'b0;
  logic reset_n = 1'b0, enable = 1'b0;
  logic [4:0] pacman_x = '0, pacman_y = '0, ghost_x_in = '0, ghost_y_in = '0;
  logic [4:0] map_x, map_y, reg_x_out, reg_y_out;
  logic [2:0] map_tile = 3'd0;
  logic reg_en, reg_readwrite, busy, move_done;

  int vectors = 0, errors = 0;
  int moves = 0;                 // completed moves since the last reset
  int last_mx = 0, last_my = 0;  // expected map address register
  logic [2:0] tile_mem [N][N];

  ghost_move_controller #(.MOVE_PERIOD(MP), .GRID_W(N), .GRID_H(N)) dut (
    .clock_50(clock_50), .reset_n(reset_n), .enable(enable),
    .pacman_x(pacman_x), .pacman_y(pacman_y),
    .ghost_x_in(ghost_x_in), .ghost_y_in(ghost_y_in),
    .map_x(map_x), .map_y(map_y), .map_tile(map_tile),
    .reg_x_out(reg_x_out), .reg_y_out(reg_y_out),
    .reg_en(reg_en), .reg_readwrite(reg_readwrite),
    .busy(busy), .move_done(move_done)
  );

  always #10 clock_50 = ~clock_50;

  // Map ROM with one cycle of read latency.
  always @(posedge clock_50)
    map_tile <= (int'(map_x) < N && int'(map_y) < N) ? tile_mem[map_x][map_y] : TILE_WALL;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic fill_map(input int wall_pct);
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++) begin
        logic [2:0] t;
        t = 3'($urandom_range(7));
        if (int'($urandom_range(99)) < wall_pct) tile_mem[x][y] = TILE_WALL;
        else tile_mem[x][y] = (t == TILE_WALL) ? TILE_DOT : t;
      end
  endtask

  task automatic set_pos(input int gx, gy, px, py);
    ghost_x_in = 5'(gx);  ghost_y_in = 5'(gy);
    pacman_x = 5'(px);    pacman_y = 5'(py);
  endtask

  // Reference: try the ranked neighbours in order, first non-wall wins.
  // Cycles: LATCH + WRITE, +1 per off-grid skip, +2 per probed tile.
  task automatic predict(input int gx, gy, px, py, output int ex, ey, cyc);
    int tx, ty, hx, vy;
    int cx [4];
    int cy [4];
    tx = px;  ty = py;
`ifdef GHOST_SCATTER_EN
    if (moves % 80 >= 64) begin tx = 1;  ty = 1; end
`endif
    ex = gx;  ey = gy;  cyc = 2;
    if (gx == tx && gy == ty) return;
    hx = (tx > gx) ? 1 : -1;
    vy = (ty > gy) ? 1 : -1;
    if (iabs(tx - gx) >= iabs(ty - gy)) begin cx = '{hx, 0, 0, -hx}; cy = '{0, vy, -vy, 0}; end
    else begin cx = '{0, hx, -hx, 0}; cy = '{vy, 0, 0, -vy}; end
    for (int i = 0; i < 4; i++) begin
      int nx, ny;
      nx = gx + cx[i];  ny = gy + cy[i];
      if (nx < 0 || nx >= N || ny < 0 || ny >= N) cyc += 1;
      else begin
        cyc += 2;  last_mx = nx;  last_my = ny;
        if (tile_mem[nx][ny] != TILE_WALL) begin ex = nx;  ey = ny;  return; end
      end
    end
  endtask

  // Waits for the next move and observes it; returns at the negedge after WRITE.
  task automatic run_move(input bit drop_en, output int ox, oy, cyc, lat,
                          output bit ok, output bit to);
    ox = -1;  oy = -1;  cyc = 0;  lat = 0;  ok = 1'b1;  to = 1'b0;
    do begin @(negedge clock_50); lat++; end while (!busy && lat < 100);
    if (!busy) begin to = 1'b1; return; end
    if (drop_en) enable = 1'b0;
    cyc = 1;
    ok = ok && !reg_en && reg_readwrite && !move_done;
    while (!move_done && cyc < 20) begin
      @(negedge clock_50);
      cyc++;
      if (!move_done) ok = ok && !reg_en && reg_readwrite && busy;
    end
    if (!move_done) begin to = 1'b1; return; end
    ok = ok && reg_en && !reg_readwrite && busy;
    ox = int'(reg_x_out);  oy = int'(reg_y_out);
    @(negedge clock_50);
    ok = ok && !reg_en && reg_readwrite && !move_done && !busy;
    moves++;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    @(negedge clock_50);
    reset_n = 1'b1;
    moves = 0;  last_mx = 0;  last_my = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;  enable = 1'b1;
    repeat (3) @(negedge clock_50);
    vectors++;
    if ({reg_en, reg_readwrite, busy, move_done} !== 4'b0100) begin
      errors++;  $display("FAIL reset_ctrl got %b want 0100", {reg_en, reg_readwrite, busy, move_done});
    end
    vectors++;
    if ({map_x, map_y, reg_x_out, reg_y_out} !== 20'd0) begin
      errors++;  $display("FAIL reset_addr got %h want 0", {map_x, map_y, reg_x_out, reg_y_out});
    end
  endtask

  // Runs one move and compares it against hand-derived expectations.
  task automatic test_move(input string nm, input bit drop_en, input int ex, ey, ecyc, elat, emx, emy);
    int ox, oy, cyc, lat;
    bit ok, to;
    run_move(drop_en, ox, oy, cyc, lat, ok, to);
    vectors++;
    if (to || ox != ex || oy != ey) begin
      errors++;  $display("FAIL %s pos got (%0d,%0d) timeout=%0d want (%0d,%0d)", nm, ox, oy, to, ex, ey);
    end
    vectors++;
    if (cyc != ecyc) begin errors++;  $display("FAIL %s latch_to_write got %0d want %0d", nm, cyc, ecyc); end
    vectors++;
    if (lat != elat) begin errors++;  $display("FAIL %s start_delay got %0d want %0d", nm, lat, elat); end
    vectors++;
    if (!ok) begin errors++;  $display("FAIL %s write_strobes got bad want 1-cycle en/write/done", nm); end
    vectors++;
    if (map_x !== 5'(emx) || map_y !== 5'(emy)) begin
      errors++;  $display("FAIL %s map_addr got (%0d,%0d) want (%0d,%0d)", nm, map_x, map_y, emx, emy);
    end
  endtask

  task automatic test_first_move();
    fill_map(0);
    set_pos(2, 2, 10, 2);
    reset_pulse();
    test_move("first_move", 1'b0, 3, 2, 4, MP, 3, 2);
  endtask

  task automatic test_wall_detour();
    fill_map(0);
    tile_mem[3][2] = TILE_WALL;
    set_pos(2, 2, 10, 5);
    test_move("wall_detour", 1'b0, 2, 3, 6, MP, 2, 3);
  endtask

  task automatic test_boxed();
    fill_map(0);
    tile_mem[0][6] = TILE_WALL;  tile_mem[1][5] = TILE_WALL;  tile_mem[0][4] = TILE_WALL;
    set_pos(0, 5, 0, 10);
    test_move("boxed", 1'b0, 0, 5, 9, MP, 0, 4);
  endtask

  task automatic test_same_tile();
    fill_map(0);
    set_pos(0, 0, 0, 0);
    test_move("same_tile", 1'b0, 0, 0, 2, MP, 0, 4);
  endtask

  task automatic test_reset_mid_move();
    int n;
    bit bad;
    fill_map(0);
    set_pos(2, 2, 10, 2);
    n = 0;
    do begin @(negedge clock_50); n++; end while (!busy && n < 100);
    repeat (2) @(negedge clock_50);
    reset_n = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clock_50);
      bad = bad || reg_en || !reg_readwrite || busy || move_done;
    end
    vectors++;
    if (bad || n >= 100) begin errors++;  $display("FAIL mid_reset got strobe/busy during reset want none"); end
    vectors++;
    if ({map_x, map_y, reg_x_out, reg_y_out} !== 20'd0) begin
      errors++;  $display("FAIL mid_reset_addr got %h want 0", {map_x, map_y, reg_x_out, reg_y_out});
    end
    reset_n = 1'b1;
    moves = 0;  last_mx = 0;  last_my = 0;
    test_move("after_reset", 1'b0, 3, 2, 4, MP, 3, 2);
  endtask

  task automatic test_enable_freeze();
    bit bad;
    fill_map(0);
    set_pos(5, 5, 5, 9);
    test_move("enable_drop", 1'b1, 5, 6, 4, MP, 5, 6);
    enable = 1'b1;
    repeat (3) @(negedge clock_50);
    enable = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clock_50);
      bad = bad || busy || reg_en || move_done;
    end
    vectors++;
    if (bad) begin errors++;  $display("FAIL enable_low got activity want frozen idle"); end
    enable = 1'b1;
    test_move("enable_resume", 1'b0, 5, 6, 4, MP - 3, 5, 6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 90; i++) begin
      int gx, gy, px, py, ex, ey, ecyc, ox, oy, cyc, lat;
      bit ok, to;
      fill_map(35);
      gx = int'($urandom_range(N - 1));  gy = int'($urandom_range(N - 1));
      px = int'($urandom_range(N - 1));  py = int'($urandom_range(N - 1));
      if ($urandom_range(7) == 0) begin px = gx;  py = gy; end
      set_pos(gx, gy, px, py);
      predict(gx, gy, px, py, ex, ey, ecyc);
      run_move(1'b0, ox, oy, cyc, lat, ok, to);
      vectors++;
      if (to || ox != ex || oy != ey || cyc != ecyc || lat != MP || !ok) begin
        errors++;
        $display("FAIL random[%0d] g=(%0d,%0d) p=(%0d,%0d) got pos=(%0d,%0d) cyc=%0d lat=%0d ok=%0d to=%0d want pos=(%0d,%0d) cyc=%0d lat=%0d",
                 i, gx, gy, px, py, ox, oy, cyc, lat, ok, to, ex, ey, ecyc, MP);
      end
      vectors++;
      if (map_x !== 5'(last_mx) || map_y !== 5'(last_my)) begin
        errors++;  $display("FAIL random_map[%0d] got (%0d,%0d) want (%0d,%0d)", i, map_x, map_y, last_mx, last_my);
      end
    end
  endtask

  initial begin
    fill_map(0);
    test_reset();
    test_first_move();
    test_wall_detour();
    test_boxed();
    test_same_tile();
    test_reset_mid_move();
    test_enable_freeze();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
